// File: rtl/window_frame_scheduler.sv
// Frame sequencer for KxK window buffers: tracks raster position,
// drives line-buffer write/shift and flags valid windows.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_i                   frame start pulse (taken only in IDLE)
//   pix_valid_i, ready_o      upstream pixel handshake
//   out_ready_i               downstream can take a window
//   lb_wr_en_o, lb_shift_o    line-buffer write / window shift (= accept)
//   win_valid_o               registered KxK window valid
//   col_o, row_o              position of last accepted pixel
//   busy_o, frame_done_o      frame in progress / end-of-frame pulse
module window_frame_scheduler #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int K     = 9,
  localparam int CW   = $clog2(IMG_W),
  localparam int RW   = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          pix_valid_i,
  input  logic          out_ready_i,
  output logic          ready_o,
  output logic          lb_wr_en_o,
  output logic          lb_shift_o,
  output logic          win_valid_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] C_WIN  = CW'(K - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_WIN  = RW'(K - 1);
  localparam logic [RW-1:0] R_FILL = RW'(K - 2);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic          accept;
  logic          row_end;
  logic          in_win;

  assign busy_o     = (state == FILL) || (state == RUN);
  assign ready_o    = busy_o & out_ready_i;
  assign accept     = pix_valid_i & ready_o;
  assign lb_wr_en_o = accept;
  assign lb_shift_o = accept;
  assign row_end    = (c == C_LAST);
  assign in_win     = (c >= C_WIN) && (r >= R_WIN);

  always_comb begin
    state_n      = state;
    frame_done_o = 1'b0;
    unique case (state)
      IDLE: if (start_i) state_n = FILL;
      FILL: if (accept && row_end && r == R_FILL) state_n = RUN;
      RUN:  if (accept && row_end && r == R_LAST) state_n = DONE;
      DONE: begin
        frame_done_o = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      c           <= '0;
      r           <= '0;
      col_o       <= '0;
      row_o       <= '0;
      win_valid_o <= 1'b0;
    end else begin
      state       <= state_n;
      win_valid_o <= accept & in_win;
      if (state == IDLE && start_i) begin
        c <= '0;
        r <= '0;
      end else if (accept) begin
        col_o <= c;
        row_o <= r;
        if (row_end) begin
          c <= '0;
          r <= r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_window_frame_scheduler.sv
// Self-checking bench for window_frame_scheduler: randomized
// pixel gaps against a raster-position reference model.
module tb_window_frame_scheduler;

  localparam int W = 8;
  localparam int H = 6;
  localparam int K = 3;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start, pv, ordy;
  logic rdy, wr, sh, wv, busy, fd;
  logic [2:0] col;
  logic [2:0] row;

  window_frame_scheduler #(.IMG_W(W), .IMG_H(H), .K(K)) dut (
    .clk(clk), .rst(rst), .start_i(start), .pix_valid_i(pv),
    .out_ready_i(ordy), .ready_o(rdy), .lb_wr_en_o(wr),
    .lb_shift_o(sh), .win_valid_o(wv), .col_o(col), .row_o(row),
    .busy_o(busy), .frame_done_o(fd)
  );

  logic start_b, pv_b, ordy_b;
  logic rdy_b, wr_b, sh_b, wv_b, busy_b, fd_b;
  logic [1:0] col_b;
  logic [1:0] row_b;

  window_frame_scheduler #(.IMG_W(3), .IMG_H(3), .K(3)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .pix_valid_i(pv_b),
    .out_ready_i(ordy_b), .ready_o(rdy_b), .lb_wr_en_o(wr_b),
    .lb_shift_o(sh_b), .win_valid_o(wv_b), .col_o(col_b),
    .row_o(row_b), .busy_o(busy_b), .frame_done_o(fd_b)
  );

  int checks = 0;
  int errors = 0;

  int q_acc[$], q_sh[$], q_rdy[$], q_or[$];
  int q_wv[$], q_col[$], q_row[$], q_fd[$];
  int s1_col[$], s1_row[$];

  int n_acc, n_win, n_fd, first_win;
  int pos_bad, wv_bad, fd_bad, sh_bad, stall_bad, hold_bad;

  task automatic drive_frame(input int gap_pct, input int stall_acc,
                             input int stall_len, input bit poke,
                             input int abort_acc, output bit timed_out);
    int nacc, stall_used, tail;
    bit fd_seen;
    q_acc.delete(); q_sh.delete(); q_rdy.delete(); q_or.delete();
    q_wv.delete(); q_col.delete(); q_row.delete(); q_fd.delete();
    nacc = 0; stall_used = 0; tail = 0; fd_seen = 0;
    timed_out = 0;
    @(negedge clk);
    start = 1; pv = 0; ordy = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (abort_acc >= 0 && nacc == abort_acc) return;
      pv = ($urandom_range(99) >= gap_pct);
      ordy = 1;
      if (stall_len > 0 && nacc == stall_acc && stall_used < stall_len) begin
        ordy = 0;
        pv = 1;
        stall_used++;
      end
      if (fd_seen) pv = 1;
      start = poke && (nacc == 20 || fd);
      #1;
      q_acc.push_back(int'(wr));
      q_sh.push_back(int'(sh));
      q_rdy.push_back(int'(rdy));
      q_or.push_back(int'(ordy));
      @(posedge clk);
      #1;
      q_wv.push_back(int'(wv));
      q_col.push_back(int'(col));
      q_row.push_back(int'(row));
      q_fd.push_back(int'(fd));
      if (q_acc[$] != 0) nacc++;
      if (fd) fd_seen = 1;
      if (fd_seen) tail++;
      if (tail > 6) break;
      @(negedge clk);
    end
    start = 0; pv = 0;
    if (abort_acc < 0 && !fd_seen) timed_out = 1;
  endtask

  task automatic analyze();
    int k, ecol, erow, ewv, efd;
    n_acc = 0; n_win = 0; n_fd = 0; first_win = -1;
    pos_bad = 0; wv_bad = 0; fd_bad = 0; sh_bad = 0;
    stall_bad = 0; hold_bad = 0;
    k = 0;
    for (int i = 0; i < q_acc.size(); i++) begin
      ewv = 0; efd = 0;
      if (q_acc[i] != 0) begin
        ecol = k % W;
        erow = k / W;
        if (q_col[i] != ecol || q_row[i] != erow) pos_bad++;
        ewv = (ecol >= K - 1 && erow >= K - 1) ? 1 : 0;
        efd = (k == NPIX - 1) ? 1 : 0;
        k++;
      end else if (i > 0) begin
        if (q_col[i] != q_col[i-1] || q_row[i] != q_row[i-1]) hold_bad++;
      end
      if (q_wv[i] != ewv) wv_bad++;
      if (q_wv[i] != 0) begin
        n_win++;
        if (first_win < 0) first_win = k - 1;
      end
      if (q_fd[i] != efd) fd_bad++;
      if (q_fd[i] != 0) n_fd++;
      if (q_sh[i] != q_acc[i]) sh_bad++;
      if (q_or[i] == 0 && (q_rdy[i] != 0 || q_acc[i] != 0)) stall_bad++;
    end
    n_acc = k;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; pv = 0; ordy = 1;
    start_b = 0; pv_b = 0; ordy_b = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rdy, wr, sh, wv, busy, fd, col, row} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0",
               {rdy, wr, sh, wv, busy, fd, col, row});
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_back_to_back();
    bit to;
    drive_frame(0, -1, 0, 0, -1, to);
    analyze();
    checks++;
    if (to) begin errors++; $display("FAIL b2b_timeout: no frame_done"); end
    checks++;
    if (n_acc != NPIX) begin
      errors++; $display("FAIL b2b_accepts: got %0d required %0d", n_acc, NPIX);
    end
    checks++;
    if (n_win != NWIN) begin
      errors++; $display("FAIL b2b_windows: got %0d required %0d", n_win, NWIN);
    end
    checks++;
    if (first_win != 2 * W + 2) begin
      errors++;
      $display("FAIL b2b_first_win: got %0d required %0d", first_win, 2 * W + 2);
    end
    checks++;
    if (n_fd != 1 || fd_bad != 0) begin
      errors++;
      $display("FAIL b2b_frame_done: got %0d pulses %0d misplaced required 1/0",
               n_fd, fd_bad);
    end
    checks++;
    if (pos_bad != 0 || wv_bad != 0 || sh_bad != 0) begin
      errors++;
      $display("FAIL b2b_model: got pos %0d wv %0d sh %0d bad required 0",
               pos_bad, wv_bad, sh_bad);
    end
    s1_col.delete(); s1_row.delete();
    for (int i = 0; i < q_acc.size(); i++)
      if (q_acc[i] != 0) begin
        s1_col.push_back(q_col[i]);
        s1_row.push_back(q_row[i]);
      end
  endtask

  task automatic test_gaps();
    bit to;
    int j, diff;
    drive_frame(30, -1, 0, 0, -1, to);
    analyze();
    diff = 0; j = 0;
    for (int i = 0; i < q_acc.size(); i++)
      if (q_acc[i] != 0) begin
        if (j >= s1_col.size() || q_col[i] != s1_col[j] || q_row[i] != s1_row[j])
          diff++;
        j++;
      end
    checks++;
    if (to || n_acc != NPIX) begin
      errors++;
      $display("FAIL gaps_accepts: got %0d (timeout %0d) required %0d", n_acc, to, NPIX);
    end
    checks++;
    if (n_win != NWIN || wv_bad != 0) begin
      errors++;
      $display("FAIL gaps_windows: got %0d (%0d bad) required %0d", n_win, wv_bad, NWIN);
    end
    checks++;
    if (diff != 0 || j != s1_col.size()) begin
      errors++;
      $display("FAIL gaps_seq: got %0d diffs over %0d required 0 over %0d",
               diff, j, s1_col.size());
    end
    checks++;
    if (hold_bad != 0 || fd_bad != 0) begin
      errors++;
      $display("FAIL gaps_hold: got hold %0d fd %0d bad required 0", hold_bad, fd_bad);
    end
  endtask

  task automatic test_stall();
    bit to;
    drive_frame(10, 3 * W + 3, 5, 0, -1, to);
    analyze();
    checks++;
    if (stall_bad != 0 || hold_bad != 0) begin
      errors++;
      $display("FAIL stall_hold: got stall %0d hold %0d bad required 0",
               stall_bad, hold_bad);
    end
    checks++;
    if (to || n_acc != NPIX || n_win != NWIN) begin
      errors++;
      $display("FAIL stall_totals: got %0d acc %0d win required %0d %0d",
               n_acc, n_win, NPIX, NWIN);
    end
    checks++;
    if (pos_bad != 0 || wv_bad != 0) begin
      errors++;
      $display("FAIL stall_model: got pos %0d wv %0d bad required 0", pos_bad, wv_bad);
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    drive_frame(20, -1, 0, 1, -1, to);
    analyze();
    checks++;
    if (to || n_fd != 1 || fd_bad != 0) begin
      errors++;
      $display("FAIL start_done: got %0d pulses %0d bad required 1", n_fd, fd_bad);
    end
    checks++;
    if (n_acc != NPIX || pos_bad != 0) begin
      errors++;
      $display("FAIL start_accepts: got %0d (%0d pos bad) required %0d",
               n_acc, pos_bad, NPIX);
    end
    #1;
    checks++;
    if (busy !== 1'b0 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL start_idle: got busy %b ready %b required 0 0", busy, rdy);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int stray;
    drive_frame(20, -1, 0, 0, 3 * W + 4, to);
    rst = 1; pv = 1; ordy = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({rdy, wr, sh, wv, busy, fd, col, row} !== 12'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b required 0",
               {rdy, wr, sh, wv, busy, fd, col, row});
    end
    @(negedge clk);
    rst = 0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (wr !== 1'b0 || busy !== 1'b0 || fd !== 1'b0) stray++;
      @(negedge clk);
    end
    pv = 0;
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_mid_idle: got %0d active cycles required 0", stray);
    end
    drive_frame(25, -1, 0, 0, -1, to);
    analyze();
    checks++;
    if (to || n_acc != NPIX || n_win != NWIN || n_fd != 1 || pos_bad != 0) begin
      errors++;
      $display("FAIL rst_mid_frame: got %0d acc %0d win %0d done required %0d %0d 1",
               n_acc, n_win, n_fd, NPIX, NWIN);
    end
  endtask

  task automatic test_small();
    int nacc, wins, fds, win_at, fd_at;
    nacc = 0; wins = 0; fds = 0; win_at = -1; fd_at = -1;
    @(negedge clk);
    start_b = 1;
    @(negedge clk);
    start_b = 0; pv_b = 1; ordy_b = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (wr_b) nacc++;
      @(posedge clk);
      #1;
      if (wv_b) begin wins++; win_at = nacc; end
      if (fd_b) begin fds++; fd_at = nacc; end
      @(negedge clk);
    end
    pv_b = 0;
    checks++;
    if (nacc != 9 || wins != 1 || win_at != 9) begin
      errors++;
      $display("FAIL small_window: got %0d acc %0d win at %0d required 9 1 at 9",
               nacc, wins, win_at);
    end
    checks++;
    if (fds != 1 || fd_at != 9) begin
      errors++;
      $display("FAIL small_done: got %0d pulses at %0d required 1 at 9", fds, fd_at);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
